// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

   localparam int MUX_ARB_N     = 16;
   localparam int MUX_ARB_IDX_W = $clog2(MUX_ARB_N);

   typedef logic [MUX_ARB_IDX_W-1:0] arb_idx_t;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/mux_16to1.sv
// Sixteen-way WIDTH-bit data selector driven by a 4-bit select line.
module mux_16to1 #(
   parameter int WIDTH = 8
) (
   input  logic [16*WIDTH-1:0] in_data,
   input  logic [3:0]          select_line,
   output logic [WIDTH-1:0]    out_data
);

   logic [WIDTH-1:0] lanes [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      assign lanes[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   assign out_data = lanes[select_line];

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping modulo N.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [MUX_ARB_N-1:0] req,
   input  arb_idx_t             last,
   output logic                 any,
   output arb_idx_t             idx
);

   arb_idx_t             start;
   arb_idx_t             enc;
   logic [MUX_ARB_N-1:0] rot;

   assign start = last + arb_idx_t'(1);

   // Rotate so the search start lands on bit 0; index arithmetic wraps naturally.
   for (genvar gi = 0; gi < MUX_ARB_N; gi++) begin : g_rot
      assign rot[gi] = req[arb_idx_t'(gi) + start];
   end

   always_comb begin
      enc = '0;
      for (int i = MUX_ARB_N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc = arb_idx_t'(i);
         end
      end
   end

   assign any = |req;
   assign idx = enc + start;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one datapath between 16 requesters with burst hold.
// Optional MUX_ARB_PRIO_EN adds prio_mask: masked requesters win arbitration first.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N         = 16,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   in_data,
`ifdef MUX_ARB_PRIO_EN
   input  logic [N-1:0]         prio_mask,
`endif
   output logic [N-1:0]         ack,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [$clog2(N)-1:0] out_src,
   output logic                 busy
);

   if (N != MUX_ARB_N) begin : g_bad_n
      $error("mux_rr_arbiter: only N=16 is supported");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("mux_rr_arbiter: MAX_BURST must be 1..255");
   end

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   arb_state_t  state_reg;
   arb_idx_t    grant_reg;
   arb_idx_t    last_reg;
   logic [7:0]  beats_reg;
   logic        busy_reg;

   logic [N-1:0]     pick_req;
   logic             pick_any;
   arb_idx_t         pick_idx;
   logic [WIDTH-1:0] mux_data;
   logic             transfer;
   logic             in_grant;

`ifdef MUX_ARB_PRIO_EN
   logic [N-1:0] prio_req;
   assign prio_req = req & prio_mask;
   assign pick_req = (|prio_req) ? prio_req : req;
`else
   assign pick_req = req;
`endif

   rr_pick u_pick (
      .req  (pick_req),
      .last (last_reg),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   mux_16to1 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .in_data     (in_data),
      .select_line (grant_reg),
      .out_data    (mux_data)
   );

   // Valid follows the granted request live, so a withdrawal drops it the same cycle.
   assign in_grant  = (state_reg == ARB_GRANT);
   assign out_valid = in_grant & req[grant_reg];
   assign transfer  = out_valid & out_ready;
   assign ack       = transfer ? (N'(1) << grant_reg) : '0;
   assign out_src   = grant_reg;
   assign out_data  = in_grant ? mux_data : '0;
   assign busy      = busy_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ARB_IDLE;
         grant_reg <= '0;
         last_reg  <= arb_idx_t'(N - 1);
         beats_reg <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_reg <= pick_idx;
                  beats_reg <= '0;
                  state_reg <= ARB_GRANT;
                  busy_reg  <= 1'b1;
               end
            end
            ARB_GRANT: begin
               if (!req[grant_reg] || (transfer && beats_reg == BURST_LAST)) begin
                  state_reg <= ARB_IDLE;
                  last_reg  <= grant_reg;
                  busy_reg  <= 1'b0;
               end else if (transfer) begin
                  beats_reg <= beats_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= ARB_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; define MUX_ARB_PRIO_EN to cover prio_mask.
module tb_mux_rr_arbiter;

   localparam int N     = 16;
   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       ack;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [3:0]         out_src;
   logic               busy;
`ifdef MUX_ARB_PRIO_EN
   logic [N-1:0]       prio_mask;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(
      .N         (N),
      .WIDTH     (WIDTH),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
`ifdef MUX_ARB_PRIO_EN
      .prio_mask (prio_mask),
`endif
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .busy      (busy)
   );

   function automatic logic [7:0] data_of(input int i);
      if (i == 5) return 8'hA5;
      return 8'(8'h30 + i);
   endfunction

   // Full observation {busy, out_valid, out_src, ack, out_data}
   function automatic logic [29:0] snap();
      return {busy, out_valid, out_src, ack, out_data};
   endfunction

   function automatic logic [29:0] granted(input int g, input logic acked);
      logic [15:0] a;
      a = acked ? (16'd1 << g) : 16'd0;
      return {1'b1, 1'b1, 4'(g), a, data_of(g)};
   endfunction

   // Reduced observation {busy, out_valid, ack} for idle / withdrawn cycles
   function automatic logic [17:0] snap_idle();
      return {busy, out_valid, ack};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
`ifdef MUX_ARB_PRIO_EN
      prio_mask = '0;
`endif
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (snap() !== 30'd0) $display("FAIL reset_outputs got=%h want=%h", snap(), 30'd0);
      else passed++;
      $display("test_reset: outputs after reset = %h", snap());
   endtask

   task automatic test_single();
      req = 16'd1 << 5;
      out_ready = 1'b1;
      #1;
      total++;
      if (snap_idle() !== 18'd0) $display("FAIL single_req_cycle0 got=%h want=%h", snap_idle(), 18'd0);
      else passed++;
      for (int b = 0; b < 4; b++) begin
         tick();
         total++;
         if (snap() !== granted(5, 1'b1))
            $display("FAIL single_beat%0d got=%h want=%h", b, snap(), granted(5, 1'b1));
         else passed++;
      end
      tick();
      total++;
      if (snap_idle() !== 18'd0) $display("FAIL single_bubble got=%h want=%h", snap_idle(), 18'd0);
      else passed++;
      tick();
      total++;
      if (snap() !== granted(5, 1'b1)) $display("FAIL single_regrant got=%h want=%h", snap(), granted(5, 1'b1));
      else passed++;
      req = '0;
      #1;
      total++;
      if (snap_idle() !== {1'b1, 1'b0, 16'd0}) $display("FAIL single_drop got=%h want=%h", snap_idle(), {1'b1, 1'b0, 16'd0});
      else passed++;
      tick();
      $display("test_single: done");
   endtask

   task automatic test_all_requesters();
      do_reset();
      req = 16'hFFFF;
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         for (int b = 0; b < 4; b++) begin
            tick();
            total++;
            if (snap() !== granted(k % 16, 1'b1))
               $display("FAIL rotate_g%0d_b%0d got=%h want=%h", k, b, snap(), granted(k % 16, 1'b1));
            else passed++;
         end
         tick();
         total++;
         if (snap_idle() !== 18'd0) $display("FAIL rotate_bubble%0d got=%h want=%h", k, snap_idle(), 18'd0);
         else passed++;
         $display("test_all_requesters: grant %0d checked", k % 16);
      end
      req = '0;
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      req = 16'd1 << 3;
      out_ready = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (snap() !== granted(3, 1'b0)) $display("FAIL stall_c%0d got=%h want=%h", i, snap(), granted(3, 1'b0));
         else passed++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      for (int b = 0; b < 4; b++) begin
         total++;
         if (snap() !== granted(3, 1'b1)) $display("FAIL stall_release_b%0d got=%h want=%h", b, snap(), granted(3, 1'b1));
         else passed++;
         tick();
      end
      total++;
      if (snap_idle() !== 18'd0) $display("FAIL stall_end got=%h want=%h", snap_idle(), 18'd0);
      else passed++;
      req = '0;
      tick();
      $display("test_stall: done");
   endtask

   task automatic test_withdraw();
      do_reset();
      req = (16'd1 << 7) | (16'd1 << 8);
      out_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         tick();
         total++;
         if (snap() !== granted(7, 1'b1)) $display("FAIL withdraw_b%0d got=%h want=%h", b, snap(), granted(7, 1'b1));
         else passed++;
      end
      req = 16'd1 << 8;
      #1;
      total++;
      if (snap_idle() !== {1'b1, 1'b0, 16'd0}) $display("FAIL withdraw_drop got=%h want=%h", snap_idle(), {1'b1, 1'b0, 16'd0});
      else passed++;
      tick();
      total++;
      if (snap_idle() !== 18'd0) $display("FAIL withdraw_idle got=%h want=%h", snap_idle(), 18'd0);
      else passed++;
      tick();
      total++;
      if (snap() !== granted(8, 1'b1)) $display("FAIL withdraw_next got=%h want=%h", snap(), granted(8, 1'b1));
      else passed++;
      req = '0;
      tick();
      tick();
      $display("test_withdraw: done");
   endtask

   // Runs right after test_withdraw, so the pointer sits at 8 before the reset.
   task automatic test_reset_mid_burst();
      req = 16'd1 << 2;
      out_ready = 1'b1;
      tick();
      total++;
      if (snap() !== granted(2, 1'b1)) $display("FAIL midrst_grant got=%h want=%h", snap(), granted(2, 1'b1));
      else passed++;
      rst_n = 1'b0;
      tick();
      total++;
      if (snap() !== 30'd0) $display("FAIL midrst_outputs got=%h want=%h", snap(), 30'd0);
      else passed++;
      req = (16'd1 << 2) | (16'd1 << 9);
      rst_n = 1'b1;
      tick();
      total++;
      if (snap() !== granted(2, 1'b1)) $display("FAIL midrst_first got=%h want=%h", snap(), granted(2, 1'b1));
      else passed++;
      req = '0;
      tick();
      tick();
      $display("test_reset_mid_burst: done");
   endtask

`ifdef MUX_ARB_PRIO_EN
   task automatic test_prio();
      do_reset();
      prio_mask = 16'h0100;
      req = 16'h0101;
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int b = 0; b < 4; b++) begin
            tick();
            total++;
            if (snap() !== granted(8, 1'b1)) $display("FAIL prio_r%0d_b%0d got=%h want=%h", r, b, snap(), granted(8, 1'b1));
            else passed++;
         end
         tick();
         total++;
         if (snap_idle() !== 18'd0) $display("FAIL prio_bubble%0d got=%h want=%h", r, snap_idle(), 18'd0);
         else passed++;
      end
      req = 16'h0001;
      tick();
      total++;
      if (snap() !== granted(0, 1'b1)) $display("FAIL prio_low got=%h want=%h", snap(), granted(0, 1'b1));
      else passed++;
      req = '0;
      prio_mask = '0;
      tick();
      tick();
      $display("test_prio: done");
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
`ifdef MUX_ARB_PRIO_EN
      prio_mask = '0;
`endif
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = data_of(i);
      test_reset();
      test_single();
      test_all_requesters();
      test_stall();
      test_withdraw();
      test_reset_mid_burst();
`ifdef MUX_ARB_PRIO_EN
      test_prio();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
